// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes and FSM state encoding shared by the SPI flash responder
package spi_flash_pkg;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PROG  = 8'h02;
  localparam logic [7:0] OP_ERASE = 8'h20;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, STATUS, PROG, IGNORE} st_t;
endpackage

// File: rtl/spi_byte_shift.sv
// spi_byte_shift: synchronizes the SPI pins, detects edges, shifts bytes in and out MSB first (mode 0)
//   clk, rst          system clock, async active-low reset
//   spi_clk/cs/di     raw SPI pins from the initiator
//   tx_data           byte to send next, captured at each byte boundary
//   cs_fall, cs_rise  chip-select edge strobes
//   bit_in, byte_done strobe per received bit / per completed byte
//   rx_byte           received byte, complete when byte_done is high
//   spi_do            MISO
module spi_byte_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_di,
  input  logic [7:0] tx_data,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       bit_in,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       spi_do
);
  // [1:0] are the synchronizer flops, [2] is the previous value for edge detection
  logic [2:0] sck_s, cs_s;
  logic [1:0] di_s;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] tx;
  logic       do_r, sck_fall;
  assign bit_in    = sck_s[1] & ~sck_s[2] & ~cs_s[1];
  assign sck_fall  = ~sck_s[1] & sck_s[2] & ~cs_s[1];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign byte_done = bit_in & (cnt == 3'd7);
  assign rx_byte   = {rx, di_s[1]};
  assign spi_do    = do_r | spi_cs;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sck_s <= '0;
      cs_s  <= '1;
      di_s  <= '0;
      cnt   <= '0;
      rx    <= '0;
      tx    <= '1;
      do_r  <= 1'b1;
    end else begin
      sck_s <= {sck_s[1:0], spi_clk};
      cs_s  <= {cs_s[1:0], spi_cs};
      di_s  <= {di_s[0], spi_di};
      if (cs_s[1]) begin
        cnt  <= '0;
        tx   <= '1;
        do_r <= 1'b1;
      end else begin
        if (bit_in) begin
          cnt <= cnt + 3'd1;
          rx  <= rx_byte[6:0];
          if (byte_done) tx <= tx_data;
        end
        // refill with ones so an unloaded byte idles MISO high
        if (sck_fall) begin
          do_r <= tx[7];
          tx   <= {tx[6:0], 1'b1};
        end
      end
    end
endmodule

// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI NOR flash responder emulating a small window of bytes (read, program, 4K erase, status, WREN/WRDI)
//   BASE_ADDR, MEM_BYTES  emulated window; BUSY_CNT  clk cycles wip stays set after program/erase
//   clk, rst              system clock, async active-low reset
//   spi_clk/cs/di/do      SPI mode 0 target pins
//   wip, wel              status bits 0 and 1
module spi_flash_resp
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h1ffd80,
  parameter int          MEM_BYTES = 16,
  parameter int          BUSY_CNT  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_di,
  output logic spi_do,
  output logic wip,
  output logic wel
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int BW = $clog2(BUSY_CNT + 1);
  st_t         st, st_nx, cmd_nx, addr_nx;
  logic [7:0]  cmd, rx_byte, tx_data, rd_byte;
  logic [23:0] addr, addr_full, cur, off;
  logic [1:0]  nb;
  logic        got, era, era_hit, hit, prog_we, erase_now;
  logic        cs_fall, cs_rise, bit_in, byte_done;
  logic [BW-1:0] busy;
  // stored inverted so that zero power-up state reads back as erased 8'hFF
  logic [7:0]  mem_n [MEM_BYTES];
  spi_byte_shift u_shift (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_di(spi_di),
    .tx_data(tx_data), .cs_fall(cs_fall), .cs_rise(cs_rise), .bit_in(bit_in),
    .byte_done(byte_done), .rx_byte(rx_byte), .spi_do(spi_do)
  );
  assign wip       = |busy;
  assign addr_full = {addr[15:0], rx_byte};
  // the first read byte is fetched in the same cycle the last address byte completes
  assign cur       = st == ADDR ? addr_full : addr;
  assign off       = cur - BASE_ADDR;
  assign hit       = off < 24'(MEM_BYTES);
  assign rd_byte   = hit ? ~mem_n[off[AW-1:0]] : 8'hFF;
  assign prog_we   = byte_done & (st == PROG) & hit;
  assign erase_now = cs_rise & era & era_hit & wel;
  always_comb begin
    cmd_nx  = rx_byte == OP_RDSR ? STATUS : wip ? IGNORE :
              (rx_byte == OP_READ || rx_byte == OP_PROG || rx_byte == OP_ERASE) ? ADDR : IGNORE;
    addr_nx = cmd == OP_READ ? READ : (cmd == OP_PROG && wel) ? PROG : IGNORE;
    st_nx   = cs_rise ? IDLE : cs_fall ? CMD : !byte_done ? st :
              st == CMD ? cmd_nx : (st == ADDR && nb == 2'd2) ? addr_nx : st;
    tx_data = ((st == CMD && rx_byte == OP_RDSR) || st == STATUS) ? {6'b0, wel, wip} :
              ((st == ADDR && nb == 2'd2 && cmd == OP_READ) || st == READ) ? rd_byte : 8'hFF;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= st_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cmd     <= '0;
      addr    <= '0;
      nb      <= '0;
      got     <= 1'b0;
      era     <= 1'b0;
      era_hit <= 1'b0;
      wel     <= 1'b0;
      busy    <= '0;
    end else begin
      if (wip) busy <= busy - BW'(1);
      if (cs_fall) begin
        nb  <= '0;
        got <= 1'b0;
        era <= 1'b0;
      end
      // an erase only counts with exactly 24 address bits, so any extra bit cancels it
      if (bit_in && st == IGNORE) era <= 1'b0;
      if (byte_done && st == CMD) begin
        cmd <= rx_byte;
        wel <= wip ? wel : rx_byte == OP_WREN ? 1'b1 : rx_byte == OP_WRDI ? 1'b0 : wel;
      end
      if (byte_done && st == ADDR) begin
        nb      <= nb + 2'd1;
        addr    <= (nb == 2'd2 && cmd == OP_READ) ? addr_full + 24'd1 : addr_full;
        era     <= nb == 2'd2 && cmd == OP_ERASE;
        era_hit <= addr_full[23:12] == BASE_ADDR[23:12];
      end
      if (byte_done && st == READ) addr <= addr + 24'd1;
      if (byte_done && st == PROG) begin
        got       <= 1'b1;
        addr[7:0] <= addr[7:0] + 8'd1;
      end
      if (cs_rise && ((st == PROG && got) || (era && wel))) begin
        wel  <= 1'b0;
        busy <= BW'(BUSY_CNT);
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < MEM_BYTES; i++)
      if (erase_now) mem_n[i] <= '0;
      else if (prog_we && off[AW-1:0] == AW'(i)) mem_n[i] <= mem_n[i] | ~rx_byte;
endmodule

// File: tb/tb_spi_flash_resp.sv
// tb_spi_flash_resp: scoreboard bench driving SPI transactions into spi_flash_resp
module tb_spi_flash_resp;
  localparam int BUSY = 1000;
  localparam int H    = 8;
  logic clk = 0, rst = 0, spi_clk = 0, spi_cs = 1, spi_di = 0;
  logic spi_do, wip, wel;
  logic [7:0] b;
  int checks = 0, errors = 0, wip_cyc = 0;
  logic [8:0] exp_q[$];

  spi_flash_resp #(.BUSY_CNT(BUSY)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_di(spi_di),
    .spi_do(spi_do), .wip(wip), .wel(wel)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (wip) wip_cyc++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xbits(input logic [7:0] o, input int n, output logic [7:0] in);
    in = '0;
    for (int i = 0; i < n; i++) begin
      spi_di = o[7-i];
      tick(H);
      spi_clk = 1;
      in = {in[6:0], spi_do};
      tick(H);
      spi_clk = 0;
    end
  endtask

  task automatic xfer(input logic [7:0] o);
    logic [7:0] d;
    xbits(o, 8, d);
  endtask

  task automatic cs_lo;
    spi_cs = 0;
    tick(4);
  endtask

  task automatic cs_hi;
    tick(H);
    spi_cs = 1;
    tick(H);
  endtask

  task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
    cs_lo;
    xfer(op);
    xfer(a[23:16]);
    xfer(a[15:8]);
    xfer(a[7:0]);
  endtask

  task automatic pull(input string tag, input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      xbits(8'hFF, 8, d);
      chk(tag, {23'b0, d}, exp_q.size() != 0 ? {23'b0, exp_q.pop_front()} : 32'h100);
    end
    cs_hi;
  endtask

  task automatic rd(input logic [23:0] a, input int n, input string tag);
    cmd_addr(8'h03, a);
    pull(tag, n);
  endtask

  task automatic stat(input int n, input string tag);
    cs_lo;
    xfer(8'h05);
    pull(tag, n);
  endtask

  task automatic wr(input logic [7:0] op);
    cs_lo;
    xfer(op);
    cs_hi;
  endtask

  task automatic prog(input logic [23:0] a, input int n, input logic [31:0] d);
    cmd_addr(8'h02, a);
    for (int i = 0; i < n; i++) xfer(d[31-8*i -: 8]);
    cs_hi;
  endtask

  task automatic erase(input logic [23:0] a);
    cmd_addr(8'h20, a);
    cs_hi;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (wip && n < 4 * BUSY) begin
      tick(1);
      n++;
    end
    chk("busy_done", {31'b0, wip}, 0);
  endtask

  task automatic push(input logic [7:0] v, input int n);
    repeat (n) exp_q.push_back({1'b0, v});
  endtask

  initial begin
    tick(4);
    chk("rst_do", {31'b0, spi_do}, 1);
    chk("rst_wip", {31'b0, wip}, 0);
    chk("rst_wel", {31'b0, wel}, 0);
    rst = 1;
    tick(4);
    push(8'hFF, 4);
    rd(24'h1ffd80, 4, "rd_blank");
    chk("blank_wip", {31'b0, wip}, 0);
    chk("blank_wel", {31'b0, wel}, 0);
    prog(24'h1ffd80, 1, 32'h55000000);
    chk("nowren_wel", {31'b0, wel}, 0);
    chk("nowren_wip", {31'b0, wip}, 0);
    push(8'hFF, 1);
    rd(24'h1ffd80, 1, "rd_nowren");
    wr(8'h06);
    chk("wren", {31'b0, wel}, 1);
    wip_cyc = 0;
    prog(24'h1ffd84, 4, 32'hB02E7F14);
    chk("prog_wel", {31'b0, wel}, 0);
    push(8'h01, 1);
    stat(1, "stat_busy");
    wr(8'h06);
    chk("wren_busy", {31'b0, wel}, 0);
    wait_idle;
    chk("wip_len", wip_cyc, BUSY);
    push(8'h00, 2);
    stat(2, "stat_idle");
    push(8'hFF, 1); push(8'hB0, 1); push(8'h2E, 1); push(8'h7F, 1); push(8'h14, 1); push(8'hFF, 1);
    rd(24'h1ffd83, 6, "rd_prog");
    push(8'hFF, 2);
    rd(24'h1ffd7e, 2, "rd_below");
    wr(8'h06);
    prog(24'h1ffd8f, 2, 32'hA53C0000);
    wait_idle;
    push(8'hFF, 1); push(8'hA5, 1); push(8'hFF, 1);
    rd(24'h1ffd8e, 3, "rd_top_edge");
    wr(8'h06);
    prog(24'h1ffd84, 1, 32'h0F000000);
    wait_idle;
    push(8'h00, 1); push(8'h2E, 1);
    rd(24'h1ffd84, 2, "rd_and");
    wr(8'h06);
    erase(24'h000000);
    chk("erase_miss_wel", {31'b0, wel}, 0);
    chk("erase_miss_wip", {31'b0, wip}, 1);
    wait_idle;
    push(8'h00, 1);
    rd(24'h1ffd84, 1, "rd_erase_miss");
    wr(8'h06);
    erase(24'h1ff000);
    wait_idle;
    push(8'hFF, 16);
    rd(24'h1ffd80, 16, "rd_erased");
    wr(8'h06);
    cs_lo;
    xfer(8'h02);
    xfer(8'h1f);
    xbits(8'hFF, 4, b);
    cs_hi;
    chk("abort_wel", {31'b0, wel}, 1);
    chk("abort_wip", {31'b0, wip}, 0);
    push(8'hFF, 1);
    rd(24'h1ffd80, 1, "rd_abort");
    wr(8'h04);
    chk("wrdi", {31'b0, wel}, 0);
    wr(8'h06);
    prog(24'h1ffd80, 1, 32'hAA000000);
    chk("busy_pre", {31'b0, wip}, 1);
    cs_lo;
    xfer(8'h05);
    xbits(8'hFF, 3, b);
    rst = 0;
    tick(1);
    chk("rst_busy_wip", {31'b0, wip}, 0);
    chk("rst_busy_wel", {31'b0, wel}, 0);
    chk("rst_busy_do", {31'b0, spi_do}, 1);
    cs_hi;
    rst = 1;
    tick(4);
    push(8'hAA, 1);
    rd(24'h1ffd80, 1, "rd_after_rst");
    push(8'h00, 1);
    stat(1, "stat_after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
